// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter
//
// Bridges the load/store exec unit's decoupled memory request onto a single-outstanding
// req/ack data bus and returns exactly one response per request (loads and stores alike).
// A watchdog ends a bus transaction that never sees bus_ack, so the exec unit cannot
// deadlock behind a hung bus.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   mem_req_*      decoupled request in: valid/ready, addr[31:0], we, be[3:0], data[31:0]
//   mem_resp_*     decoupled response out: valid/ready, data[31:0]
//   bus_req        bus transaction request, held until ack or timeout
//   bus_we         write enable
//   bus_addr       word address, passed through unmodified
//   bus_be         byte enables
//   bus_wdata      write data
//   bus_ack        one-cycle completion strobe from the bus
//   bus_rdata      read data, valid with bus_ack
//   busy           high in any state other than idle
//   timeout_err    one-cycle pulse when the watchdog fires
//
// Parameters:
//   TIMEOUT        max cycles bus_req may stay high without bus_ack; 0 disables the watchdog
//   ERR_DATA       response data returned on a timed-out transaction

module mem_bus_adapter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [31:0] mem_req_addr,
  input  logic        mem_req_we,
  input  logic [3:0]  mem_req_be,
  input  logic [31:0] mem_req_data,

  output logic        mem_resp_valid,
  input  logic        mem_resp_ready,
  output logic [31:0] mem_resp_data,

  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,

  output logic        busy,
  output logic        timeout_err
);

  // Counter is wide enough to hold TIMEOUT itself; at least one bit when disabled.
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TimeoutLastInt = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutLastInt);
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e        state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   resp_q;
  logic          bus_req_q;
  logic          resp_valid_q;
  logic          timeout_err_q;
  logic          timeout_hit;

  // Counter holds the number of BUS cycles already completed, so the check against
  // TIMEOUT-1 fires in the TIMEOUT-th cycle of bus_req.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      resp_q        <= '0;
      bus_req_q     <= 1'b0;
      resp_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (mem_req_valid) begin
            addr_q    <= mem_req_addr;
            we_q      <= mem_req_we;
            be_q      <= mem_req_be;
            wdata_q   <= mem_req_data;
            cnt_q     <= '0;
            bus_req_q <= 1'b1;
            state_q   <= StBus;
          end
        end
        StBus: begin
          if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntW'(1);
          end
          // Ack takes priority over a watchdog expiring in the same cycle.
          if (bus_ack) begin
            resp_q       <= we_q ? 32'h0 : bus_rdata;
            bus_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else if (timeout_hit) begin
            resp_q        <= ERR_DATA;
            bus_req_q     <= 1'b0;
            resp_valid_q  <= 1'b1;
            timeout_err_q <= 1'b1;
            state_q       <= StResp;
          end
        end
        StResp: begin
          if (mem_resp_ready) begin
            resp_valid_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= StIdle;
          end
        end
        default: begin
          bus_req_q    <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign mem_req_ready  = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign mem_resp_valid = resp_valid_q;
  assign mem_resp_data  = resp_q;
  assign bus_req        = bus_req_q;
  assign bus_we         = we_q;
  assign bus_addr       = addr_q;
  assign bus_be         = be_q;
  assign bus_wdata      = wdata_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: doc/mem_bus_adapter.md
Name: mem_bus_adapter

Overview:
Downstream neighbour of the load/store exec unit. Consumes its word-aligned memory request (addr, we, be, wdata) over a decoupled handshake and drives a single-outstanding req/ack data bus. Returns one mtrans response per request, for loads and stores alike. A watchdog timeout terminates hung bus transactions so the exec unit can never deadlock.

Parameters:
TIMEOUT, 64, max cycles bus_req may stay high without bus_ack; 0 disables the watchdog
ERR_DATA, 32'hDEAD_BEEF, response data returned on a timed-out transaction

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  decoupled.in  -  request: data.a addr[31:0], data.we 1, data.be [3:0], data.d mtrans[31:0]
mem_resp  decoupled.out  -  response: data mtrans[31:0]
bus_req  out  1  bus transaction request, held until ack
bus_we  out  1  write enable
bus_addr  out  32  word address, passed through unmodified
bus_be  out  4  byte enables
bus_wdata  out  32  write data
bus_ack  in  1  one-cycle completion strobe from bus
bus_rdata  in  32  read data, valid with bus_ack
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. bus_req=0, mem_resp.valid=0, busy=0, timeout_err=0, counter=0. The address, data and response registers are cleared to 0. bus_req drops in the same cycle that rst_n asserts.
- FSM states: IDLE, BUS, RESP. Only one transaction is outstanding at any time.
- IDLE:
  - mem_req.ready=1.
  - On mem_req.valid&&ready, latch a/we/be/d into registers and go to BUS.
  - mem_req.ready=0 in all other states.
- BUS:
  - bus_req=1. bus_we/addr/be/wdata are driven from the latched registers and stay stable for the whole state.
  - Counter increments each cycle.
  - On bus_ack: the response register takes bus_rdata if we=0, or 32'h0 if we=1. Go to RESP.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack: response register takes ERR_DATA, timeout_err pulses for 1 cycle, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins and there is no error pulse.
- RESP:
  - mem_resp.valid=1, mem_resp.data holds the response register.
  - On mem_resp.ready, go to IDLE and clear the counter.
  - valid stays high and data stays stable until ready.
- Latency: request accepted in cycle N; bus_req high from N+1; ack in cycle M (M≥N+1); mem_resp.valid high in M+1. The minimum round trip is 2 cycles from accept to resp valid. A new request can be accepted at the earliest 1 cycle after the resp handshake.
- bus_ack outside BUS, including a late ack after a timeout, is ignored and does not disturb state.
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit. The counter saturates and never wraps. It resets on entry to BUS.
- No address or alignment checking. be=4'b0000 is forwarded as-is and still completes normally.
- Outputs are registered or decoded purely from state. There is no combinational path from mem_req to bus_* or from bus_ack to mem_resp.valid.

Test Plan:
- Load: req a=0x100, we=0, be=4'hF in cycle 0. Bus acks in cycle 3 with rdata=0x12345678. Required: bus_req high cycles 1–3, mem_resp.valid in cycle 4 with data=0x12345678, busy low from cycle 5.
- Store: a=0x204, we=1, be=4'b1100, d=0xABCD0000, ack in cycle 1. Required: bus_we=1, bus_be=1100, bus_wdata=0xABCD0000 stable while bus_req is high; resp data=0; mem_req.ready=0 until resp handshake.
- Backpressure: resp ready held low for 5 cycles. Required: valid and data stable throughout, a second mem_req.valid is not accepted, and it is accepted the cycle after ready rises.
- Timeout: TIMEOUT=8, no ack. Required: bus_req high 8 cycles, then drops; timeout_err single pulse; resp data=0xDEADBEEF. A late ack 2 cycles later is ignored with no extra response.
- Reset mid-BUS: assert rst_n low 2 cycles into BUS. Required: bus_req=0 immediately and state returns to IDLE. After release, an ack is ignored and a fresh request completes normally.
- Ack/timeout collision: TIMEOUT=4, ack in cycle 4 of BUS. Required: resp carries rdata and timeout_err stays 0.
